game_layer_compositor: RTL and testbench

- Parametrised successor to the game's top-level pixel compositor.
- Merges NUM_LAYERS sprite layers, camera background, game border and start-menu image into one 24-bit pixel per clock.
- Adds over the current block: a START/PLAY/OVER mode FSM, configurable border geometry, a hit-flash effect counted in frames, and a fixed registered pipeline with aligned hcount/vcount outputs.
- Sits between the sprite generators and the video output (TMDS/HDMI) path.

---
 rtl/game_layer_compositor.sv | 187 ++++++++++++++++++
 tb/tb_game_layer_compositor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_layer_compositor.sv
// game_layer_compositor
//   Merges NUM_LAYERS sprite layers, the camera background, the game border
//   and the start-menu image into one 24-bit pixel per clock, with a
//   START/PLAY/OVER mode FSM and a frame-counted hit-flash effect.
//   Two registered pipeline stages; hcount/vcount are delayed to match.
//
// Ports
//   clk_in              pixel clock
//   rst_in              synchronous active-high reset
//   hcount_in/vcount_in current pixel column/row
//   nf_in               new-frame pulse (one cycle)
//   ir_in               last decoded IR remote code
//   camera_sw           1 enables the camera background
//   camera_pixel_in     camera pixel, aligned with hcount_in
//   start_pixel_in      start-menu pixel, aligned with hcount_in
//   layers_in           packed layer colours, layer k at [24k+23:24k], 0 = transparent
//   player_health_in    player health
//   opponent_health_in  opponent health
//   pixel_out           composited pixel (2-cycle latency)
//   hcount_out          hcount_in delayed 2 cycles
//   vcount_out          vcount_in delayed 2 cycles
//   mode_out            0 = START, 1 = PLAY, 2 = OVER
module game_layer_compositor #(
    parameter int          NUM_LAYERS   = 8,
    parameter int          BORDER_X     = 960,
    parameter int          BORDER_Y     = 640,
    parameter int          FLASH_FRAMES = 8,
    parameter logic [23:0] BORDER_COLOR = 24'hFF_FF_FF,
    parameter logic [23:0] FLASH_COLOR  = 24'hFF_00_00,
    parameter logic [31:0] START_CODE_A = 32'h20DF_5BA4,
    parameter logic [31:0] START_CODE_B = 32'h20DF_5AA5
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [10:0]              hcount_in,
    input  logic [9:0]               vcount_in,
    input  logic                     nf_in,
    input  logic [31:0]              ir_in,
    input  logic                     camera_sw,
    input  logic [23:0]              camera_pixel_in,
    input  logic [23:0]              start_pixel_in,
    input  logic [NUM_LAYERS*24-1:0] layers_in,
    input  logic [2:0]               player_health_in,
    input  logic [2:0]               opponent_health_in,
    output logic [23:0]              pixel_out,
    output logic [10:0]              hcount_out,
    output logic [9:0]               vcount_out,
    output logic [1:0]               mode_out
);

    typedef enum logic [1:0] {
        MODE_START = 2'd0,
        MODE_PLAY  = 2'd1,
        MODE_OVER  = 2'd2
    } mode_t;

    localparam int FW = $clog2(FLASH_FRAMES + 1);

    mode_t          mode;
    logic [31:0]    ir_prev;
    logic [2:0]     prev_player_health;
    logic [FW-1:0]  flash_cnt;
    logic           code_hit;

    // stage 1
    logic           s1_valid;
    logic [23:0]    s1_color;
    logic           s1_border;
    logic [23:0]    s1_bg;
    logic [23:0]    s1_start;
    logic [10:0]    hcount_d1;
    logic [9:0]     vcount_d1;

    logic           sel_valid;
    logic [23:0]    sel_color;
    logic           border;
    logic [23:0]    pixel_next;
    logic [23:0]    bg_mod;

    assign code_hit = (ir_in == START_CODE_A) || (ir_in == START_CODE_B);
    assign mode_out = mode;

    // ---------------- mode FSM and hit flash ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mode               <= MODE_START;
            ir_prev            <= '0;
            prev_player_health <= 3'd7;
            flash_cnt          <= '0;
        end else begin
            ir_prev <= ir_in;

            if (nf_in) begin
                prev_player_health <= player_health_in;
                if (mode == MODE_PLAY && player_health_in < prev_player_health)
                    flash_cnt <= FW'(FLASH_FRAMES);
                else if (flash_cnt != '0)
                    flash_cnt <= flash_cnt - 1'b1;
            end

            case (mode)
                MODE_START: begin
                    if (code_hit) begin
                        mode               <= MODE_PLAY;
                        prev_player_health <= player_health_in;
                    end
                end
                MODE_PLAY: begin
                    if (nf_in && (player_health_in == 3'd0 || opponent_health_in == 3'd0))
                        mode <= MODE_OVER;
                end
                MODE_OVER: begin
                    // a held code must not bounce straight back, so require a new code
                    if (code_hit && (ir_prev != ir_in))
                        mode <= MODE_START;
                end
                default: mode <= MODE_START;
            endcase
        end
    end

    // ---------------- stage 1 ----------------
    always_comb begin
        sel_valid = 1'b0;
        sel_color = '0;
        // lowest index wins: take the first nonzero layer only
        for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
            if (!sel_valid && layers_in[k*24 +: 24] != 24'd0) begin
                sel_valid = 1'b1;
                sel_color = layers_in[k*24 +: 24];
            end
        end
    end

    assign border = ((hcount_in == 11'(BORDER_X)) && (vcount_in <= 10'(BORDER_Y))) ||
                    ((vcount_in == 10'(BORDER_Y)) && (hcount_in <= 11'(BORDER_X)));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_valid  <= 1'b0;
            s1_color  <= '0;
            s1_border <= 1'b0;
            s1_bg     <= '0;
            s1_start  <= '0;
            hcount_d1 <= '0;
            vcount_d1 <= '0;
        end else begin
            s1_valid  <= sel_valid;
            s1_color  <= sel_color;
            s1_border <= border;
            s1_bg     <= camera_sw ? camera_pixel_in : 24'd0;
            s1_start  <= start_pixel_in;
            hcount_d1 <= hcount_in;
            vcount_d1 <= vcount_in;
        end
    end

    // ---------------- stage 2 ----------------
    always_comb begin
        bg_mod = s1_bg;
        if (mode == MODE_PLAY && flash_cnt[0])
            bg_mod = FLASH_COLOR;       // odd count is necessarily nonzero
        else if (mode == MODE_OVER)
            bg_mod = (s1_bg >> 1) & 24'h7F_7F_7F;

        pixel_next = bg_mod;
        if (mode == MODE_START)
            pixel_next = s1_start;
        else if (s1_border)
            pixel_next = BORDER_COLOR;
        else if (s1_valid)
            pixel_next = s1_color;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pixel_out  <= '0;
            hcount_out <= '0;
            vcount_out <= '0;
        end else begin
            pixel_out  <= pixel_next;
            hcount_out <= hcount_d1;
            vcount_out <= vcount_d1;
        end
    end

endmodule

// File: tb/tb_game_layer_compositor.sv
module tb_game_layer_compositor;

    localparam int NL = 8;

    logic          clk;
    logic          rst;
    logic [10:0]   hcount;
    logic [9:0]    vcount;
    logic          nf;
    logic [31:0]   ir;
    logic          cam_sw;
    logic [23:0]   cam_px;
    logic [23:0]   start_px;
    logic [NL*24-1:0] layers;
    logic [2:0]    p_health;
    logic [2:0]    o_health;
    logic [23:0]   pixel;
    logic [10:0]   hcount_o;
    logic [9:0]    vcount_o;
    logic [1:0]    mode;

    game_layer_compositor #(.NUM_LAYERS(NL)) dut (
        .clk_in(clk), .rst_in(rst),
        .hcount_in(hcount), .vcount_in(vcount),
        .nf_in(nf), .ir_in(ir),
        .camera_sw(cam_sw), .camera_pixel_in(cam_px),
        .start_pixel_in(start_px), .layers_in(layers),
        .player_health_in(p_health), .opponent_health_in(o_health),
        .pixel_out(pixel), .hcount_out(hcount_o), .vcount_out(vcount_o),
        .mode_out(mode)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 pixel, 1 mode, 2 hcount, 3 vcount
    typedef struct {
        int unsigned cyc;
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // expectation due 'dly' posedges after the current one, checked at the following negedge
    task automatic expect_at(input int unsigned dly, input int kind,
                             input logic [31:0] val, input string name);
        exp_t e;
        e.cyc  = cyc + dly;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_layers();
        layers = '0;
    endtask

    task automatic set_layer(input int k, input logic [23:0] c);
        layers[k*24 +: 24] = c;
    endtask

    // monitor: compare every expectation whose cycle has come
    initial begin
        logic [31:0] act;
        forever begin
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= cyc) begin
                    case (sb[i].kind)
                        0:       act = {8'd0, pixel};
                        1:       act = {30'd0, mode};
                        2:       act = {21'd0, hcount_o};
                        default: act = {22'd0, vcount_o};
                    endcase
                    n_cmp++;
                    if (sb[i].cyc != cyc) begin
                        n_bad++;
                        $display("FAIL %s: missed at cycle %0d (due %0d) expected %h",
                                 sb[i].name, cyc, sb[i].cyc, sb[i].val);
                    end else if (act !== sb[i].val) begin
                        n_bad++;
                        $display("FAIL %s: cycle %0d got %h expected %h",
                                 sb[i].name, cyc, act, sb[i].val);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    logic [23:0] flash_exp [10];

    initial begin
        flash_exp[0] = 24'h404040;   // count 8
        flash_exp[1] = 24'hFF0000;   // 7
        flash_exp[2] = 24'h404040;   // 6
        flash_exp[3] = 24'hFF0000;   // 5
        flash_exp[4] = 24'h404040;   // 4
        flash_exp[5] = 24'hFF0000;   // 3
        flash_exp[6] = 24'h404040;   // 2
        flash_exp[7] = 24'hFF0000;   // 1
        flash_exp[8] = 24'h404040;   // 0
        flash_exp[9] = 24'h404040;   // stays 0

        rst = 1'b1; hcount = '0; vcount = '0; nf = 1'b0; ir = '0;
        cam_sw = 1'b0; cam_px = '0; start_px = 24'h123456;
        layers = '0; p_health = 3'd3; o_health = 3'd3;

        // reset state
        step();
        expect_at(1, 0, 32'h0, "reset_pixel");
        expect_at(1, 1, 32'd0, "reset_mode");
        expect_at(1, 2, 32'd0, "reset_hcount");
        step();

        // idle START: start image, hcount/vcount 2-cycle delay
        rst = 1'b0; hcount = 11'd37; vcount = 10'd12;
        expect_at(1, 2, 32'd0, "hcount_d1_not_yet");
        expect_at(2, 2, 32'd37, "hcount_delay2");
        expect_at(2, 3, 32'd12, "vcount_delay2");
        expect_at(2, 0, 32'h123456, "start_pixel");
        expect_at(1, 1, 32'd0, "idle_mode_start");
        step(); step(); step();

        // enter PLAY, layer priority
        ir = 32'h20DF_5BA4; hcount = 11'd100; vcount = 10'd100;
        set_layer(2, 24'h00FF00); set_layer(5, 24'h0000FF);
        expect_at(1, 1, 32'd1, "enter_play");
        expect_at(2, 0, 32'h00FF00, "layer2_over_layer5");
        step();
        ir = '0;
        clear_layers(); set_layer(5, 24'h0000FF); set_layer(7, 24'hABCDEF);
        expect_at(2, 0, 32'h0000FF, "layer5_over_layer7");
        step();

        // border geometry
        for (int k = 0; k < NL; k++) set_layer(k, 24'h00FF00);
        hcount = 11'd960; vcount = 10'd300;
        expect_at(2, 0, 32'hFFFFFF, "border_vertical");
        step();
        hcount = 11'd500; vcount = 10'd640;
        expect_at(2, 0, 32'hFFFFFF, "border_horizontal");
        step();
        hcount = 11'd960; vcount = 10'd641;
        expect_at(2, 0, 32'h00FF00, "below_vertical_border");
        step();
        hcount = 11'd961; vcount = 10'd640;
        expect_at(2, 0, 32'h00FF00, "right_of_horizontal_border");
        step();
        hcount = 11'd960; vcount = 10'd640;
        expect_at(2, 0, 32'hFFFFFF, "border_corner");
        step();

        // hit flash over camera background
        clear_layers(); hcount = 11'd100; vcount = 10'd100;
        cam_sw = 1'b1; cam_px = 24'h404040; p_health = 3'd2;
        expect_at(2, 0, 32'h404040, "camera_bg_no_flash");
        step(); step();
        for (int i = 0; i < 10; i++) begin
            nf = 1'b1;
            step();
            nf = 1'b0;
            expect_at(2, 0, {8'd0, flash_exp[i]}, $sformatf("flash_frame%0d", i));
            step(); step();
        end

        // start another flash, reset while the count is odd
        p_health = 3'd1; nf = 1'b1; step(); nf = 1'b0; step();
        nf = 1'b1; step(); nf = 1'b0;
        expect_at(2, 0, 32'hFF0000, "flash_before_reset");
        step(); step();
        rst = 1'b1;
        expect_at(1, 0, 32'h0, "midline_reset_pixel");
        expect_at(1, 1, 32'd0, "midline_reset_mode");
        step();
        rst = 1'b0; ir = 32'h20DF_5BA4;
        expect_at(1, 1, 32'd1, "replay_after_reset");
        expect_at(2, 0, 32'h404040, "flash_cleared_by_reset");
        step();
        ir = '0; step();

        // game over, halved background, held code ignored
        ir = 32'h20DF_5AA5; step();
        o_health = 3'd0; nf = 1'b1;
        expect_at(1, 1, 32'd2, "enter_over");
        step();
        nf = 1'b0; cam_px = 24'h808080;
        expect_at(2, 0, 32'h404040, "over_bg_halved");
        step();
        cam_px = 24'hFF11EE;
        expect_at(2, 0, 32'h7F0877, "over_bg_halved_mixed");
        step(); step();
        expect_at(1, 1, 32'd2, "held_code_stays_over");
        step();
        ir = '0; step();
        ir = 32'h20DF_5AA5;
        expect_at(1, 1, 32'd0, "over_to_start");
        expect_at(2, 1, 32'd1, "held_code_restarts_play");
        step(); step(); step(); step();

        foreach (sb[i]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: never checked, expected %h", sb[i].name, sb[i].val);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
